// File: rtl/imm_decode_stage_pkg.sv
// Shared immediate format codes and RV opcode constants for the front-end decoders.
package imm_decode_stage_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_X    = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    // The *W opcodes only exist on RV64; on RV32 they fall through to illegal.
    function automatic imm_fmt_e opc_fmt(input logic [6:0] opc, input logic rv64);
        imm_fmt_e f;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: f = FMT_I;
            OPC_OP_IMM32: f = rv64 ? FMT_I : FMT_X;
            OPC_STORE:    f = FMT_S;
            OPC_BRANCH:   f = FMT_B;
            OPC_LUI, OPC_AUIPC: f = FMT_U;
            OPC_JAL:      f = FMT_J;
            OPC_OP:       f = FMT_NONE;
            OPC_OP32:     f = rv64 ? FMT_NONE : FMT_X;
            default:      f = FMT_X;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_decode_stage_extract.sv
// imm_extract: combinational instruction -> {format, illegal, sign-extended immediate}.
module imm_extract
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [2:0]      imm_type,
    output logic            illegal,
    output logic            is_tgt,
    output logic [XLEN-1:0] imm
);

    imm_fmt_e           fmt;
    logic signed [31:0] imm32;

    always_comb begin
        fmt   = opc_fmt(inst[6:0], XLEN == 64);
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U: imm32 = {inst[31:12], 12'h000};
            FMT_J: imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm      = XLEN'(imm32);
    assign imm_type = fmt;
    assign illegal  = (fmt == FMT_X);
    assign is_tgt   = (fmt == FMT_B) || (fmt == FMT_J) || (inst[6:0] == OPC_AUIPC);

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a 2-entry skid buffer (output reg + skid reg).
// Define IMM_DECODE_TARGET_EN to compute the pc+imm branch/jump target.
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_target,
    output logic             out_tgt_vld
);

    typedef struct packed {
        logic [31:0]      inst;
        logic [XLEN-1:0]  pc;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  imm;
        logic [2:0]       imm_type;
        logic             illegal;
        logic [XLEN-1:0]  target;
        logic             tgt_vld;
    } entry_t;

    logic [2:0]      x_type;
    logic            x_illegal;
    logic            x_is_tgt;
    logic [XLEN-1:0] x_imm;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst     (in_inst),
        .imm_type (x_type),
        .illegal  (x_illegal),
        .is_tgt   (x_is_tgt),
        .imm      (x_imm)
    );

    entry_t in_ent, out_ent, skid_ent;
    logic   out_vld, skid_vld, in_ready_r;
    logic   accept;

    always_comb begin
        in_ent          = '0;
        in_ent.inst     = in_inst;
        in_ent.pc       = in_pc;
        in_ent.tag      = in_tag;
        in_ent.imm      = x_imm;
        in_ent.imm_type = x_type;
        in_ent.illegal  = x_illegal;
`ifdef IMM_DECODE_TARGET_EN
        in_ent.target   = x_is_tgt ? in_pc + x_imm : '0;
        in_ent.tgt_vld  = x_is_tgt;
`endif
    end

`ifndef IMM_DECODE_TARGET_EN
    logic unused_is_tgt;
    assign unused_is_tgt = x_is_tgt;
`endif

    assign accept = in_valid && in_ready_r;

    // in_ready is registered: it only falls once the skid slot is actually occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ent    <= '0;
            skid_ent   <= '0;
            out_vld    <= 1'b0;
            skid_vld   <= 1'b0;
            in_ready_r <= 1'b1;
        end else if (flush) begin
            out_vld    <= 1'b0;
            skid_vld   <= 1'b0;
            in_ready_r <= 1'b1;
        end else if (!out_vld || out_ready) begin
            if (skid_vld) begin
                out_ent    <= skid_ent;
                out_vld    <= 1'b1;
                skid_vld   <= 1'b0;
                in_ready_r <= 1'b1;
            end else if (accept) begin
                out_ent <= in_ent;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (accept) begin
            skid_ent   <= in_ent;
            skid_vld   <= 1'b1;
            in_ready_r <= 1'b0;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_vld;
    assign out_inst    = out_ent.inst;
    assign out_pc      = out_ent.pc;
    assign out_tag     = out_ent.tag;
    assign out_imm     = out_ent.imm;
    assign out_type    = out_ent.imm_type;
    assign out_illegal = out_ent.illegal;
    assign out_target  = out_ent.target;
    assign out_tgt_vld = out_ent.tgt_vld;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed vectors, skid/flush/reset scenarios, random scoreboard.
module tb_imm_decode_stage;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_inst = '0;
    logic [XLEN-1:0]  in_pc = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_inst;
    logic [XLEN-1:0]  out_pc;
    logic [TAG_W-1:0] out_tag;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_type;
    logic             out_illegal;
    logic [XLEN-1:0]  out_target;
    logic             out_tgt_vld;

    imm_decode_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_tag(out_tag),
        .out_imm(out_imm), .out_type(out_type), .out_illegal(out_illegal),
        .out_target(out_target), .out_tgt_vld(out_tgt_vld)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [3:0]  tag;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tgt;
        logic        tv;
    } exp_t;

    // Reference: immediates assembled arithmetically from field weights.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc, input logic [3:0] tag);
        exp_t e;
        int   v;
        logic tk;
        e.inst = inst; e.pc = pc; e.tag = tag; e.ill = 1'b0; v = 0; tk = 1'b0;
        case (inst[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin e.fmt = 3'd1; v = $signed(inst) >>> 20; end
            7'h23: begin e.fmt = 3'd2; v = ($signed(inst) >>> 25) * 32 + int'(inst[11:7]); end
            7'h63: begin
                e.fmt = 3'd3; tk = 1'b1;
                v = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
            end
            7'h37: begin e.fmt = 3'd4; v = int'(inst & 32'hFFFFF000); end
            7'h17: begin e.fmt = 3'd4; v = int'(inst & 32'hFFFFF000); tk = 1'b1; end
            7'h6F: begin
                e.fmt = 3'd5; tk = 1'b1;
                v = (inst[31] ? -1048576 : 0) + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
            end
            7'h33: e.fmt = 3'd0;
            default: begin e.fmt = 3'd6; e.ill = 1'b1; end
        endcase
        e.imm = 32'(v);
`ifdef IMM_DECODE_TARGET_EN
        e.tgt = tk ? pc + 32'(v) : 32'h0;
        e.tv  = tk;
`else
        e.tgt = 32'h0;
        e.tv  = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] opcs [13] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                                  7'h17, 7'h6F, 7'h33, 7'h1B, 7'h3B, 7'h7F};
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) return r;
        return {r[31:7], opcs[$urandom_range(0, 12)]};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({out_valid, in_ready, out_inst, out_pc, out_tag, out_imm, out_type, out_illegal, out_target, out_tgt_vld}
            !== {1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: out_valid=%0b in_ready=%0b imm=%h type=%0d tag=%h, want 0/1/0/0/0",
                     out_valid, in_ready, out_imm, out_type, out_tag);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] insts [5] = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h0000007F, 32'h0200006F};
        logic [31:0] pcs   [5] = '{32'h0, 32'h100, 32'h2000, 32'h40, 32'hFFFFFFF0};
        logic [31:0] imms  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h0, 32'h20};
        logic [2:0]  typs  [5] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd5};
`ifdef IMM_DECODE_TARGET_EN
        logic [31:0] tgts  [5] = '{32'h0, 32'hFC, 32'h0, 32'h0, 32'h10};
`else
        logic [31:0] tgts  [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`endif
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            e = model(insts[i], pcs[i], 4'(i));
            in_valid = 1'b1; in_inst = insts[i]; in_pc = pcs[i]; in_tag = 4'(i); out_ready = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            n_tests++;
            if ({out_valid, out_imm, out_type, out_target} !== {1'b1, imms[i], typs[i], tgts[i]}) begin
                n_fail++;
                $display("FAIL directed[%0d] literal: valid=%0b imm=%h type=%0d tgt=%h, want 1 %h %0d %h",
                         i, out_valid, out_imm, out_type, out_target, imms[i], typs[i], tgts[i]);
            end
            n_tests++;
            if ({out_inst, out_pc, out_tag, out_imm, out_type, out_illegal, out_target, out_tgt_vld}
                !== {e.inst, e.pc, e.tag, e.imm, e.fmt, e.ill, e.tgt, e.tv}) begin
                n_fail++;
                $display("FAIL directed[%0d] model: imm=%h type=%0d ill=%0b tgt=%h tv=%0b, want %h %0d %0b %h %0b",
                         i, out_imm, out_type, out_illegal, out_target, out_tgt_vld, e.imm, e.fmt, e.ill, e.tgt, e.tv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e [3];
        int   idx_in = 0, idx_out = 0, cyc = 0;
        for (int i = 0; i < 3; i++) e[i] = model(rand_inst(), $urandom, 4'(i + 1));
        while (idx_out < 3 && cyc < 20) begin
            in_valid  = (idx_in < 3);
            if (idx_in < 3) begin in_inst = e[idx_in].inst; in_pc = e[idx_in].pc; in_tag = e[idx_in].tag; end
            out_ready = (cyc >= 3);
            @(negedge clk);
            if (cyc == 2) begin
                n_tests++;
                if ({in_ready, out_valid} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL b2b_stall: in_ready=%0b out_valid=%0b, want 0 1", in_ready, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if ({out_tag, out_inst, out_imm, out_type} !== {e[idx_out].tag, e[idx_out].inst, e[idx_out].imm, e[idx_out].fmt}) begin
                    n_fail++;
                    $display("FAIL b2b_order: tag=%h inst=%h, want %h %h", out_tag, out_inst, e[idx_out].tag, e[idx_out].inst);
                end
                idx_out++;
            end
            if (in_valid && in_ready) idx_in++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (idx_out != 3) begin
            n_fail++;
            $display("FAIL b2b_count: drained %0d entries, want 3", idx_out);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_dup: out_valid=%0b after drain, want 0", out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        exp_t e;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_inst = rand_inst(); in_tag = 4'(4 + i);
            @(posedge clk); #1;
        end
        flush = 1'b1; in_valid = 1'b1; in_tag = 4'hF; in_inst = 32'h00000013;
        @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_full: in_ready=%0b out_valid=%0b, want 0 1", in_ready, out_valid);
        end
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_clear: in_ready=%0b out_valid=%0b, want 1 0", in_ready, out_valid);
        end
        // Flush on an empty, ready stage must also discard the same-cycle input.
        @(posedge clk); #1 flush = 1'b1; in_valid = 1'b1; in_tag = 4'hE;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_discard: out_valid=%0b tag=%h, want 0", out_valid, out_tag);
        end
        e = model(32'h00A00513, 32'h80, 4'h6);
        @(posedge clk); #1 in_valid = 1'b1; in_inst = e.inst; in_pc = e.pc; in_tag = e.tag;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({out_valid, out_tag, out_imm, out_type} !== {1'b1, e.tag, e.imm, e.fmt}) begin
            n_fail++;
            $display("FAIL flush_after: valid=%0b tag=%h imm=%h, want 1 %h %h", out_valid, out_tag, out_imm, e.tag, e.imm);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_inst = rand_inst(); in_pc = $urandom; in_tag = 4'(8 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, in_ready, out_tag, out_imm} !== {1'b0, 1'b1, 4'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_async: out_valid=%0b in_ready=%0b tag=%h imm=%h, want 0 1 0 0",
                     out_valid, in_ready, out_tag, out_imm);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic acc, fire;
        int   occ_bad = 0;
        for (int cyc = 0; cyc < 410; cyc++) begin
            if (cyc >= 400) begin
                in_valid = 1'b0; out_ready = 1'b1;
            end else begin
                if (!in_valid || acc) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_inst  = rand_inst(); in_pc = $urandom; in_tag = 4'($urandom);
                end
                out_ready = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            n_tests++;
            if ({out_valid, in_ready} !== {q.size() != 0, q.size() < 2}) begin
                n_fail++; occ_bad++;
                if (occ_bad < 5)
                    $display("FAIL rand_occ cyc %0d: out_valid=%0b in_ready=%0b, want %0b %0b",
                             cyc, out_valid, in_ready, q.size() != 0, q.size() < 2);
            end
            if (out_valid && q.size() != 0) begin
                e = q[0];
                n_tests++;
                if ({out_inst, out_pc, out_tag, out_imm, out_type, out_illegal, out_target, out_tgt_vld}
                    !== {e.inst, e.pc, e.tag, e.imm, e.fmt, e.ill, e.tgt, e.tv}) begin
                    n_fail++;
                    $display("FAIL rand_data cyc %0d: inst=%h imm=%h type=%0d tgt=%h, want %h %h %0d %h",
                             cyc, out_inst, out_imm, out_type, out_target, e.inst, e.imm, e.fmt, e.tgt);
                end
            end
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            @(posedge clk);
            if (fire && q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back(model(in_inst, in_pc, in_tag));
            #1;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: %0d entries never emerged, want 0", q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
